hci_core_merge: RTL and testbench
=================================

# hci_core_merge

Width-merging join for HCI core interfaces: gathers NB_IN_CHAN narrow requests (one per input channel, possibly arriving on different cycles) into a single wide request of DW bits, issues it on one wide master port, and fans the wide response back out to the narrow channels. It sits between several narrow initiators (e.g. per-lane streamers) and a wide TCDM or interconnect port. It is the inverse of the core-interface width splitter.

## Interface
- DW, 64: wide data width of tcdm_master; narrow width DW_IN = DW/NB_IN_CHAN, BW_IN = DW_IN/8.
- NB_IN_CHAN, 2: number of narrow input channels; power of two, DW_IN ≥ 8.
- AW, 32: address width on all ports.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- clear_i  input  1  synchronous clear; same effect as reset.
- tcdm_slave[NB_IN_CHAN]  hci_core_intf.slave  DW_IN data  narrow request ports.
- tcdm_master  hci_core_intf.master  DW data  wide request port.
- err_o  output  1  sticky consistency error flag.

## Operation
- Per-channel slot: holds add, wen, be, data of one captured narrow request; flag full[i].
- Capture: slave[i].gnt = slave[i].req & ~full[i]; when high, payload latched and full[i] set next cycle.
- FSM states: COLLECT, ISSUE, WAIT_RSP.
  - COLLECT: master.req=0; when &full → ISSUE.
  - ISSUE: master.req=1, payload from slots; on master.gnt → clear all full[i], write/read → WAIT_RSP.
  - WAIT_RSP: master.req=0; on master.r_valid → COLLECT (or ISSUE directly if &full already at that cycle).
- Capture stays enabled in all states; slots refill while WAIT_RSP is pending. At most one wide transaction outstanding.
- Wide payload: add = slot[0].add; wen = slot[0].wen; be = {be[N-1],…,be[0]}; data = {data[N-1],…,data[0]}; boffs='0; user='0.
- Response: slave[i].r_valid = master.r_valid (only in WAIT_RSP, else 0); slave[i].r_data = master.r_data[(i+1)*DW_IN-1 : i*DW_IN]; slave[i].r_opc = master.r_opc; r_user='0.
- master.lrdy = &slave[i].lrdy.
- Consistency check on ISSUE cycle with master.gnt: for i>0, slot[i].add ≠ slot[0].add + i*BW_IN or slot[i].wen ≠ slot[0].wen → err_o set, stays 1 until reset/clear. Transaction still proceeds with channel-0 address/wen.
- Address arithmetic modulo 2^AW (wrap silently).

## Timing
- Reset/clear: state=COLLECT, full='0, slots='0, err_o=0, master.req=0, all slave gnt follow req (slots empty), slave r_valid=0.
- Latency: last narrow gnt at cycle N → master.req at N+1; earliest.
- Narrow gnt is combinational from req and full; master.req is registered-state only (no combinational path from slave req).
- Wide gnt clears slots for cycle N+1; a channel with req held high is re-granted at N+1.
- Response passthrough combinational, zero added latency; wide r_valid may arrive any cycle ≥1 after gnt.
- Simultaneous master.r_valid and &full in WAIT_RSP: go to ISSUE next cycle.
- Channel requesting while full: gnt=0, request held per HCI rules.
- clear_i mid-transaction: pending wide response dropped (no narrow r_valid forwarded after clear); user must quiesce master first.

## Structure
- hci_package: typedef enum hci_merge_state_t {COLLECT, ISSUE, WAIT_RSP}.
- Sub-module hci_core_merge_slot: one per channel, holds payload + full flag, capture/clear inputs.
- Top: FSM, wide payload concatenation, response fan-out, err_o check.

## Test plan
- NB_IN_CHAN=2, DW=64: ch0 req add=0x100 data=0xAAAA_AAAA, ch1 add=0x104 data=0x5555_5555 same cycle -> both gnt cycle 0; master.req cycle 1, add=0x100, data=0x5555_5555_AAAA_AAAA, be=0xFF; err_o=0.
- Staggered: ch0 req cycle 0, ch1 req cycle 3 -> master.req first at cycle 4; ch0 gnt only at cycle 0.
- Read: master.r_valid with r_data=0x1122_3344_5566_7788 -> ch0 r_data=0x5566_7788, ch1 r_data=0x1122_3344, both r_valid same cycle.
- Back-pressure: master.gnt held 0 for 5 cycles -> master.req stays 1, slots not overwritten, second narrow reqs get gnt=0 until wide gnt.
- Mismatch: ch1 add=0x108 (expected 0x104) -> transaction issued at 0x100, err_o=1 from next cycle until clear_i.
- Reset mid-WAIT_RSP: assert rst_ni=0 -> all outputs at reset values; subsequent fresh transaction completes normally.

Source files
------------

// File: rtl/hci_core_merge_pkg.sv
// Shared types for the HCI width-merging join.
// State encoding and fixed side-band widths.
package hci_core_merge_pkg;

   typedef enum logic [1:0] {
      COLLECT,
      ISSUE,
      WAIT_RSP
   } hci_merge_state_t;

   localparam int unsigned BOFFS_W = 16;

endpackage

// File: rtl/hci_core_merge_slot.sv
// One narrow-channel holding slot: payload plus full flag.
// Capture wins over release; reset and clear empty it.
module hci_core_merge_slot
   import hci_core_merge_pkg::*;
#(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clear_i,
   input  logic            capture_i,
   input  logic            release_i,
   input  logic [AW-1:0]   add_i,
   input  logic            wen_i,
   input  logic [DW/8-1:0] be_i,
   input  logic [DW-1:0]   data_i,
   output logic            full_o,
   output logic [AW-1:0]   add_o,
   output logic            wen_o,
   output logic [DW/8-1:0] be_o,
   output logic [DW-1:0]   data_o
);

   // payload and occupancy register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         full_o <= 1'b0;
         add_o  <= '0;
         wen_o  <= 1'b0;
         be_o   <= '0;
         data_o <= '0;
      end else if (clear_i) begin
         full_o <= 1'b0;
         add_o  <= '0;
         wen_o  <= 1'b0;
         be_o   <= '0;
         data_o <= '0;
      end else if (capture_i) begin
         full_o <= 1'b1;
         add_o  <= add_i;
         wen_o  <= wen_i;
         be_o   <= be_i;
         data_o <= data_i;
      end else if (release_i) begin
         full_o <= 1'b0;
      end
   end

endmodule

// File: rtl/hci_core_merge.sv
// Gathers NB_IN_CHAN narrow HCI requests into one wide
// request and fans the wide response back out.
module hci_core_merge
   import hci_core_merge_pkg::*;
#(
   parameter int unsigned DW         = 64,
   parameter int unsigned NB_IN_CHAN = 2,
   parameter int unsigned AW         = 32,
   parameter int unsigned UW         = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   input  logic [NB_IN_CHAN-1:0]    tcdm_slave_req,
   output logic [NB_IN_CHAN-1:0]    tcdm_slave_gnt,
   input  logic [NB_IN_CHAN*AW-1:0] tcdm_slave_add,
   input  logic [NB_IN_CHAN-1:0]    tcdm_slave_wen,
   input  logic [DW/8-1:0]          tcdm_slave_be,
   input  logic [DW-1:0]            tcdm_slave_data,
   output logic [DW-1:0]            tcdm_slave_r_data,
   output logic [NB_IN_CHAN-1:0]    tcdm_slave_r_valid,
   output logic [NB_IN_CHAN-1:0]    tcdm_slave_r_opc,
   output logic [NB_IN_CHAN*UW-1:0] tcdm_slave_r_user,
   input  logic [NB_IN_CHAN-1:0]    tcdm_slave_lrdy,
   output logic                     tcdm_master_req,
   input  logic                     tcdm_master_gnt,
   output logic [AW-1:0]            tcdm_master_add,
   output logic                     tcdm_master_wen,
   output logic [DW/8-1:0]          tcdm_master_be,
   output logic [DW-1:0]            tcdm_master_data,
   output logic [BOFFS_W-1:0]       tcdm_master_boffs,
   output logic [UW-1:0]            tcdm_master_user,
   input  logic [DW-1:0]            tcdm_master_r_data,
   input  logic                     tcdm_master_r_valid,
   input  logic                     tcdm_master_r_opc,
   output logic                     tcdm_master_lrdy,
   output logic                     err_o
);

   localparam int unsigned DW_IN = DW / NB_IN_CHAN;
   localparam int unsigned BW_IN = DW_IN / 8;

   hci_merge_state_t state_q, state_d;

   logic [NB_IN_CHAN-1:0] full;
   logic [AW-1:0]         slot_add [NB_IN_CHAN];
   logic [NB_IN_CHAN-1:0] slot_wen;
   logic [DW/8-1:0]       slot_be;
   logic [DW-1:0]         slot_data;
   logic                  all_full_nxt;
   logic                  issue;
   logic                  rsp_en;
   logic                  release_w;
   logic                  mismatch;

   assign tcdm_slave_gnt = tcdm_slave_req & ~full;
   assign all_full_nxt   = &(full | tcdm_slave_gnt);
   assign release_w      = issue & tcdm_master_gnt;

   for (genvar g = 0; g < NB_IN_CHAN; g++) begin : g_slot
      hci_core_merge_slot #(
         .AW (AW),
         .DW (DW_IN)
      ) i_slot (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .clear_i   (clear_i),
         .capture_i (tcdm_slave_gnt[g]),
         .release_i (release_w),
         .add_i     (tcdm_slave_add[g*AW +: AW]),
         .wen_i     (tcdm_slave_wen[g]),
         .be_i      (tcdm_slave_be[g*BW_IN +: BW_IN]),
         .data_i    (tcdm_slave_data[g*DW_IN +: DW_IN]),
         .full_o    (full[g]),
         .add_o     (slot_add[g]),
         .wen_o     (slot_wen[g]),
         .be_o      (slot_be[g*BW_IN +: BW_IN]),
         .data_o    (slot_data[g*DW_IN +: DW_IN])
      );
   end

   // state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      state_q <= COLLECT;
      else if (clear_i) state_q <= COLLECT;
      else              state_q <= state_d;
   end

   // next state: COLLECT looks ahead at this cycle's grants
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         COLLECT:  if (all_full_nxt) state_d = ISSUE;
         ISSUE:    if (tcdm_master_gnt) state_d = WAIT_RSP;
         WAIT_RSP: if (tcdm_master_r_valid)
                      state_d = (&full) ? ISSUE : COLLECT;
         default:  state_d = COLLECT;
      endcase
   end

   // state decode
   always_comb begin
      issue  = 1'b0;
      rsp_en = 1'b0;
      unique case (1'b1)
         (state_q == ISSUE):    issue  = 1'b1;
         (state_q == WAIT_RSP): rsp_en = 1'b1;
         default: ;
      endcase
   end

   // lane address/wen consistency against channel 0
   always_comb begin
      mismatch = 1'b0;
      for (int unsigned i = 1; i < NB_IN_CHAN; i++) begin
         if (slot_add[i] != slot_add[0] + AW'(i * BW_IN))
            mismatch = 1'b1;
         if (slot_wen[i] != slot_wen[0])
            mismatch = 1'b1;
      end
   end

   // sticky error flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                   err_o <= 1'b0;
      else if (clear_i)              err_o <= 1'b0;
      else if (release_w & mismatch) err_o <= 1'b1;
   end

   assign tcdm_master_req   = issue;
   assign tcdm_master_add   = slot_add[0];
   assign tcdm_master_wen   = slot_wen[0];
   assign tcdm_master_be    = slot_be;
   assign tcdm_master_data  = slot_data;
   assign tcdm_master_boffs = '0;
   assign tcdm_master_user  = '0;
   assign tcdm_master_lrdy  = &tcdm_slave_lrdy;

   assign tcdm_slave_r_valid =
      {NB_IN_CHAN{rsp_en & tcdm_master_r_valid}};
   assign tcdm_slave_r_data  = tcdm_master_r_data;
   assign tcdm_slave_r_opc   = {NB_IN_CHAN{tcdm_master_r_opc}};
   assign tcdm_slave_r_user  = '0;

endmodule

// File: tb/tb_hci_core_merge.sv
// Self-checking bench for hci_core_merge: directed
// scenarios plus randomized traffic against a model.
module tb_hci_core_merge;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        clear_i;
   logic [1:0]  s_req, s_gnt, s_wen, s_rvalid, s_ropc;
   logic [1:0]  s_ruser, s_lrdy;
   logic [63:0] s_add, s_data, s_rdata;
   logic [7:0]  s_be;
   logic        m_req, m_gnt, m_wen, m_rvalid, m_ropc, m_lrdy;
   logic [31:0] m_add;
   logic [63:0] m_data, m_rdata;
   logic [7:0]  m_be;
   logic [15:0] m_boffs;
   logic [0:0]  m_user;
   logic        err;

   int total = 0;
   int bad   = 0;
   bit chk_on = 0;

   always #5 clk = ~clk;

   hci_core_merge #(
      .DW(64), .NB_IN_CHAN(2), .AW(32), .UW(1)
   ) dut (
      .clk_i               (clk),
      .rst_ni              (rst_ni),
      .clear_i             (clear_i),
      .tcdm_slave_req      (s_req),
      .tcdm_slave_gnt      (s_gnt),
      .tcdm_slave_add      (s_add),
      .tcdm_slave_wen      (s_wen),
      .tcdm_slave_be       (s_be),
      .tcdm_slave_data     (s_data),
      .tcdm_slave_r_data   (s_rdata),
      .tcdm_slave_r_valid  (s_rvalid),
      .tcdm_slave_r_opc    (s_ropc),
      .tcdm_slave_r_user   (s_ruser),
      .tcdm_slave_lrdy     (s_lrdy),
      .tcdm_master_req     (m_req),
      .tcdm_master_gnt     (m_gnt),
      .tcdm_master_add     (m_add),
      .tcdm_master_wen     (m_wen),
      .tcdm_master_be      (m_be),
      .tcdm_master_data    (m_data),
      .tcdm_master_boffs   (m_boffs),
      .tcdm_master_user    (m_user),
      .tcdm_master_r_data  (m_rdata),
      .tcdm_master_r_valid (m_rvalid),
      .tcdm_master_r_opc   (m_ropc),
      .tcdm_master_lrdy    (m_lrdy),
      .err_o               (err)
   );

   task automatic check(input string nm,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: which narrow requests are
   // parked, whether a wide request is offered, whether a
   // wide response is owed, and the sticky error.
   bit [1:0]    mfull;
   logic [31:0] madd  [2];
   bit [1:0]    mwen;
   logic [3:0]  mbe   [2];
   logic [31:0] mdata [2];
   bit          mreq, mwait, merr;

   always @(posedge clk or negedge rst_ni) begin
      bit [1:0] g;
      bit       bad_lane;
      if (!rst_ni || clear_i) begin
         mfull <= '0;
         mwen  <= '0;
         mreq  <= 1'b0;
         mwait <= 1'b0;
         merr  <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            madd[i]  <= '0;
            mbe[i]   <= '0;
            mdata[i] <= '0;
         end
      end else begin
         g = s_req & ~mfull;
         bad_lane = (madd[1] != madd[0] + 32'd4) ||
                    (mwen[1] != mwen[0]);
         if (mreq && m_gnt) begin
            if (bad_lane) merr <= 1'b1;
            mreq  <= 1'b0;
            mwait <= 1'b1;
         end else if (mwait && m_rvalid) begin
            mwait <= 1'b0;
            mreq  <= (mfull == 2'b11);
         end else if (!mreq && !mwait) begin
            mreq  <= ((mfull | g) == 2'b11);
         end
         for (int i = 0; i < 2; i++) begin
            if (g[i]) begin
               mfull[i] <= 1'b1;
               madd[i]  <= s_add[i*32 +: 32];
               mwen[i]  <= s_wen[i];
               mbe[i]   <= s_be[i*4 +: 4];
               mdata[i] <= s_data[i*32 +: 32];
            end else if (mreq && m_gnt) begin
               mfull[i] <= 1'b0;
            end
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_on) begin
         check("gnt", 64'(s_gnt), 64'(s_req & ~mfull));
         check("m_req", 64'(m_req), 64'(mreq));
         if (mreq) begin
            check("m_add", 64'(m_add), 64'(madd[0]));
            check("m_wen", 64'(m_wen), 64'(mwen[0]));
            check("m_be", 64'(m_be), 64'({mbe[1], mbe[0]}));
            check("m_data", m_data, {mdata[1], mdata[0]});
         end
         check("r_valid", 64'(s_rvalid),
               64'({2{mwait & m_rvalid}}));
         check("r_data0", 64'(s_rdata[31:0]),
               64'(m_rdata[31:0]));
         check("r_data1", 64'(s_rdata[63:32]),
               64'(m_rdata[63:32]));
         check("r_opc", 64'(s_ropc), 64'({2{m_ropc}}));
         check("r_user", 64'(s_ruser), 64'(0));
         check("lrdy", 64'(m_lrdy), 64'(&s_lrdy));
         check("boffs", 64'(m_boffs), 64'(0));
         check("user", 64'(m_user), 64'(0));
         check("err", 64'(err), 64'(merr));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int       cnt [2];
   bit [1:0] gs;
   int       cmax;

   initial begin
      rst_ni = 1'b0; clear_i = 1'b0;
      s_req = '0; s_wen = '0; s_add = '0; s_be = '0;
      s_data = '0; s_lrdy = 2'b11;
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
      m_ropc = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_ni = 1'b1;
      chk_on = 1;
      @(negedge clk);
      check("rst m_req", 64'(m_req), 64'(0));
      check("rst err", 64'(err), 64'(0));
      check("rst rvalid", 64'(s_rvalid), 64'(0));

      // both lanes in the same cycle
      step();
      s_req = 2'b11; s_wen = 2'b11; s_be = 8'hFF;
      s_add = {32'h104, 32'h100};
      s_data = {32'h5555_5555, 32'hAAAA_AAAA};
      @(negedge clk);
      check("same gnt", 64'(s_gnt), 64'(2'b11));
      step();
      s_req = 2'b01;
      s_add[31:0] = 32'h200; s_data[31:0] = 32'h1234_5678;
      @(negedge clk);
      check("same add", 64'(m_add), 64'h100);
      check("same data", m_data, 64'h5555_5555_AAAA_AAAA);
      check("same be", 64'(m_be), 64'hFF);
      check("same err", 64'(err), 64'(0));

      // wide back-pressure
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp req", 64'(m_req), 64'(1));
         check("bp gnt", 64'(s_gnt), 64'(0));
         check("bp data", m_data, 64'h5555_5555_AAAA_AAAA);
         step();
      end
      m_gnt = 1'b1;
      step();
      m_gnt = 1'b0;
      @(negedge clk);
      check("regnt req", 64'(m_req), 64'(0));
      check("regnt gnt", 64'(s_gnt), 64'(2'b01));
      step();
      s_req = 2'b00;
      m_rvalid = 1'b1; m_rdata = 64'h1122_3344_5566_7788;
      @(negedge clk);
      check("rd valid", 64'(s_rvalid), 64'(2'b11));
      check("rd ch0", 64'(s_rdata[31:0]), 64'h5566_7788);
      check("rd ch1", 64'(s_rdata[63:32]), 64'h1122_3344);
      step();
      m_rvalid = 1'b0;

      // lane 1 address off by one beat
      s_req = 2'b10; s_add[63:32] = 32'h208;
      @(negedge clk);
      check("mm gnt", 64'(s_gnt), 64'(2'b10));
      step();
      s_req = 2'b00; m_gnt = 1'b1;
      @(negedge clk);
      check("mm add", 64'(m_add), 64'h200);
      check("mm err0", 64'(err), 64'(0));
      step();
      m_gnt = 1'b0;
      @(negedge clk);
      check("mm err1", 64'(err), 64'(1));
      step();
      m_rvalid = 1'b1;
      step();
      m_rvalid = 1'b0;
      @(negedge clk);
      check("mm sticky", 64'(err), 64'(1));
      step();
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      @(negedge clk);
      check("clr err", 64'(err), 64'(0));

      // staggered lanes
      step();
      s_req = 2'b01; s_add[31:0] = 32'h400;
      @(negedge clk);
      check("stg gnt0", 64'(s_gnt), 64'(2'b01));
      step();
      s_req = 2'b00;
      @(negedge clk);
      check("stg c1", 64'(m_req), 64'(0));
      step();
      @(negedge clk);
      check("stg c2", 64'(m_req), 64'(0));
      step();
      s_req = 2'b10; s_add[63:32] = 32'h404;
      @(negedge clk);
      check("stg gnt1", 64'(s_gnt), 64'(2'b10));
      check("stg c3", 64'(m_req), 64'(0));
      step();
      s_req = 2'b00; m_gnt = 1'b1;
      @(negedge clk);
      check("stg c4", 64'(m_req), 64'(1));
      check("stg add", 64'(m_add), 64'h400);
      step();

      // reset while the response is owed
      m_gnt = 1'b0; m_rvalid = 1'b1;
      rst_ni = 1'b0; s_req = 2'b11;
      @(negedge clk);
      check("mid rst rv", 64'(s_rvalid), 64'(0));
      check("mid rst req", 64'(m_req), 64'(0));
      check("mid rst gnt", 64'(s_gnt), 64'(2'b11));
      step();
      rst_ni = 1'b1; m_rvalid = 1'b0;
      s_add = {32'h504, 32'h500};
      @(negedge clk);
      check("fresh gnt", 64'(s_gnt), 64'(2'b11));
      step();
      s_req = 2'b00; m_gnt = 1'b1;
      @(negedge clk);
      check("fresh add", 64'(m_add), 64'h500);
      step();
      m_gnt = 1'b0; m_rvalid = 1'b1;
      m_rdata = 64'hCAFE_F00D_0BAD_BEEF;
      @(negedge clk);
      check("fresh rv", 64'(s_rvalid), 64'(2'b11));
      step();
      m_rvalid = 1'b0;

      // randomized traffic; lane addresses wrap at 2^32
      cnt[0] = 0; cnt[1] = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         gs = s_gnt;
         step();
         clear_i = 1'b0;
         for (int i = 0; i < 2; i++) begin
            if (s_req[i] && gs[i]) begin
               s_req[i] = 1'b0;
               cnt[i]++;
            end
         end
         if ($urandom % 150 == 0) begin
            clear_i = 1'b1;
            s_req = 2'b00;
            cmax = (cnt[0] > cnt[1]) ? cnt[0] : cnt[1];
            cnt[0] = cmax + 1; cnt[1] = cmax + 1;
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (!s_req[i] && ($urandom % 2 == 0)) begin
                  s_req[i] = 1'b1;
                  s_add[i*32 +: 32] = 32'hFFFF_FF00 +
                     32'(cnt[i] * 8) + 32'(i * 4) +
                     (($urandom % 20 == 0) ? 32'd8 : 32'd0);
                  s_wen[i] = cnt[i][0];
                  s_be[i*4 +: 4] = 4'($urandom);
                  s_data[i*32 +: 32] = $urandom;
               end
            end
         end
         m_gnt    = ($urandom % 2 == 0);
         m_rvalid = mwait && ($urandom % 3 == 0);
         m_rdata  = {$urandom, $urandom};
         m_ropc   = 1'($urandom);
         s_lrdy   = 2'($urandom);
      end
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
